matmul_mem: RTL and testbench
=============================

MATMUL_MEM -- requirements
Module: matmul_mem

Interface
REQ-001 Parameter MEM_AW, 16, address width shared with the matmul engine port.
REQ-002 Parameter MEM_DW, 32, data word width.
REQ-003 Parameter DEPTH_LOG2, 10, log2 of implemented words; it SHALL satisfy DEPTH_LOG2 <= MEM_AW.
REQ-004 The ports SHALL be, one clock and one reset, with reset asynchronous and active-high:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  engine access request, sampled every cycle, no backpressure.
- mem_write  in  1  engine write (1) or read (0).
- mem_addr  in  MEM_AW  engine word address.
- mem_wdata  in  MEM_DW  engine write data.
- mem_rdata  out  MEM_DW  engine read data.
- host_req  in  1  host access request; held until granted.
- host_write  in  1  host write (1) or read (0).
- host_addr  in  MEM_AW  host word address.
- host_wdata  in  MEM_DW  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rvalid  out  1  host read data valid, one-cycle pulse.
- host_rdata  out  MEM_DW  host read data.
- oob_err  out  1  sticky out-of-range access flag.

Function
REQ-005 The engine port SHALL have absolute priority: host_gnt = host_req & ~mem_req, combinational.
REQ-006 An access SHALL be accepted in cycle N when mem_req=1, or when host_gnt=1.
REQ-007 A write accepted in cycle N SHALL update the array at the end of N, and a read in N+1 or later SHALL return the new word.
REQ-008 A read accepted in cycle N SHALL produce its data at the output in cycle N+2: a registered array read, then an output register. Latency is fixed and fully pipelined, one read per cycle.
REQ-009 mem_rdata SHALL hold the last engine read result until the next engine read result arrives.
REQ-010 The engine SHALL be allowed to repeat an identical read in consecutive cycles, with each read returned independently at N+2.
REQ-011 host_rvalid SHALL pulse for exactly one cycle at N+2 for each granted host read.
REQ-012 host_rdata SHALL hold its value until the next host read result arrives.
REQ-013 Host writes SHALL produce no host_rvalid.
REQ-014 An address with any bit at or above DEPTH_LOG2 set SHALL be out of range:
- a write to it is dropped;
- a read of it returns 0 at N+2, with normal valid timing;
- oob_err is set and stays set until reset.
REQ-015 A read tag pipeline, 2 stages of {valid, is_host}, SHALL steer each result to the engine or the host output. The two outputs SHALL never update in the same cycle.
REQ-016 When host_req=1 and mem_req=1 in the same cycle:
- host_gnt=0;
- the host SHALL keep its request stable;
- the host is granted in the first cycle with mem_req=0.
REQ-017 When mem_req=1, the host fields (host_write, host_addr, host_wdata) SHALL have no effect.

Reset
REQ-018 Asserting rst SHALL immediately clear:
- mem_rdata = 0;
- host_rdata = 0;
- host_rvalid = 0;
- oob_err = 0;
- all tag pipeline valid bits = 0.
REQ-019 Reads in flight when reset is asserted SHALL be discarded and SHALL produce no host_rvalid after reset release.
REQ-020 Array contents SHALL NOT be reset.
REQ-021 Writes accepted before reset SHALL be preserved.

Configuration
REQ-022 With macro MATMUL_MEM_STATS_EN defined, the block SHALL add output rd_count [31:0] and output wr_count [31:0].
REQ-023 rd_count and wr_count SHALL count accepted reads and writes from both ports, including out-of-range ones.
REQ-024 rd_count and wr_count SHALL saturate at 32'hFFFFFFFF and clear on rst.
REQ-025 Without MATMUL_MEM_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Write then read: host writes 32'hDEAD0001 to addr 5 in cycle 0, engine reads addr 5 in cycle 1 -> mem_rdata = 32'hDEAD0001 in cycle 3.
REQ-027 Back-to-back engine reads: engine reads addrs 2, 3, 3 in cycles 0-2 -> mem_rdata returns the three words in cycles 2-4, in order, with the repeated read returned twice.
REQ-028 Arbitration: host_req held with a read of addr 7 while mem_req=1 in cycles 0-3 -> host_gnt=0 in cycles 0-3, host_gnt=1 in cycle 4, host_rvalid=1 only in cycle 6.
REQ-029 Out of range (DEPTH_LOG2=10): engine writes 32'h1234 to addr 16'h0400, then reads it -> mem_rdata = 0, oob_err = 1, word at addr 0 unchanged.
REQ-030 Reset mid-read: host read granted in cycle 0, rst pulsed in cycle 1 -> no host_rvalid in cycles 2-4, oob_err = 0, previously written data still readable.
REQ-031 With MATMUL_MEM_STATS_EN: 3 reads and 2 writes -> rd_count = 3, wr_count = 2; after preload of 32'hFFFFFFFF via force, one more read leaves rd_count = 32'hFFFFFFFF.

Source files
------------

// File: rtl/matmul_mem.sv
// matmul_mem: single-port word memory shared by a matmul engine port and a
// host port. The engine always has priority and the host is stalled through
// host_gnt. Reads are pipelined with a fixed two-cycle latency: array read
// register, then output register. A two-stage tag pipeline steers each
// result to the engine or the host output. Addresses beyond the implemented
// depth drop writes, read back as zero, and set the sticky oob_err flag.
// Optional feature: define MATMUL_MEM_STATS_EN to add saturating
// rd_count/wr_count outputs. DEPTH_LOG2 must not exceed MEM_AW.
module matmul_mem #(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [MEM_DW-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [MEM_DW-1:0] host_rdata,
    output logic              oob_err
`ifdef MATMUL_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // One entry per read in flight: does it exist, and which port owns it.
    typedef struct packed {
        logic valid;
        logic is_host;
    } tag_t;

    logic                  acc_valid;
    logic                  acc_write;
    logic [MEM_AW-1:0]     acc_addr;
    logic [MEM_DW-1:0]     acc_wdata;
    logic                  acc_is_host;
    logic                  acc_oob;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  wr_en;
    logic                  rd_en;

    logic [MEM_DW-1:0]     mem_q [DEPTH];
    logic [MEM_DW-1:0]     rd_data_q;
    logic [MEM_DW-1:0]     rd_word;

    tag_t                  tag1_q, tag1_d;
    tag_t                  tag2_q, tag2_d;
    logic                  rd_oob_q, rd_oob_d;
    logic [MEM_DW-1:0]     mem_rdata_q, mem_rdata_d;
    logic [MEM_DW-1:0]     host_rdata_q, host_rdata_d;
    logic                  oob_err_q, oob_err_d;

    // Arbitration: the engine wins outright; the host field values are
    // ignored whenever the engine requests.
    always_comb begin
        host_gnt    = host_req & ~mem_req;
        acc_valid   = mem_req | host_gnt;
        acc_is_host = ~mem_req;
        acc_write   = mem_req ? mem_write : host_write;
        acc_addr    = mem_req ? mem_addr  : host_addr;
        acc_wdata   = mem_req ? mem_wdata : host_wdata;
        acc_idx     = acc_addr[DEPTH_LOG2-1:0];
        acc_oob     = 1'b0;
        for (int i = DEPTH_LOG2; i < MEM_AW; i++) begin
            acc_oob = acc_oob | acc_addr[i];
        end
        wr_en = acc_valid & acc_write & ~acc_oob;
        rd_en = acc_valid & ~acc_write;
    end

    // Storage array and its registered read port.
    // NOTE: the array and its read register have no reset so they map onto
    // block RAM, and written contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[acc_idx] <= acc_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[acc_idx];
        end
    end

    // Next-state for the tag pipeline, output registers and sticky flag.
    always_comb begin
        tag1_d.valid   = rd_en;
        tag1_d.is_host = acc_is_host;
        rd_oob_d       = acc_oob;
        tag2_d         = tag1_q;
        rd_word        = rd_oob_q ? '0 : rd_data_q;
        mem_rdata_d    = mem_rdata_q;
        host_rdata_d   = host_rdata_q;
        if (tag1_q.valid && !tag1_q.is_host) begin
            mem_rdata_d = rd_word;
        end
        if (tag1_q.valid && tag1_q.is_host) begin
            host_rdata_d = rd_word;
        end
        oob_err_d = oob_err_q | (acc_valid & acc_oob);
    end

    // Pipeline and output state; reset discards reads in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1_q       <= '0;
            tag2_q       <= '0;
            rd_oob_q     <= 1'b0;
            mem_rdata_q  <= '0;
            host_rdata_q <= '0;
            oob_err_q    <= 1'b0;
        end else begin
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            rd_oob_q     <= rd_oob_d;
            mem_rdata_q  <= mem_rdata_d;
            host_rdata_q <= host_rdata_d;
            oob_err_q    <= oob_err_d;
        end
    end

    assign mem_rdata   = mem_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = tag2_q.valid & tag2_q.is_host;
    assign oob_err     = oob_err_q;

`ifdef MATMUL_MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Saturating counters of accepted accesses, out-of-range ones included.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_en && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (acc_valid && acc_write && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_matmul_mem.sv
// Directed bench for matmul_mem. Cycles are delimited by rising clock edges;
// inputs are driven and outputs sampled 1 time unit after each edge.
module tb_matmul_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        host_req, host_write;
    logic [15:0] host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_gnt, host_rvalid, oob_err;
`ifdef MATMUL_MEM_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matmul_mem #(.MEM_AW(16), .MEM_DW(32), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .oob_err(oob_err)
`ifdef MATMUL_MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic eng(input logic req, input logic wr, input logic [15:0] a, input logic [31:0] d);
        mem_req = req; mem_write = wr; mem_addr = a; mem_wdata = d;
    endtask

    task automatic hst(input logic req, input logic wr, input logic [15:0] a, input logic [31:0] d);
        host_req = req; host_write = wr; host_addr = a; host_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        eng(0, 0, 16'h0, 32'h0);
        hst(0, 0, 16'h0, 32'h0);
        cyc(); cyc();
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_host_rdata", host_rdata, 32'h0);
        check("rst_host_rvalid", host_rvalid, 32'h0);
        check("rst_oob_err", oob_err, 32'h0);
        rst = 1'b0;
        cyc();

        // Write then read: host write addr 5, engine read addr 5 next cycle.
        hst(1, 1, 16'd5, 32'hDEAD0001);
        #1 check("wr_host_gnt", host_gnt, 32'h1);
        cyc();
        hst(0, 0, 16'd0, 32'h0);
        eng(1, 0, 16'd5, 32'h0);
        cyc();
        eng(0, 0, 16'd0, 32'h0);
        cyc();
        check("wr_rd_mem_rdata", mem_rdata, 32'hDEAD0001);
        check("wr_rd_no_host_rvalid", host_rvalid, 32'h0);

        // Preload addrs 2 and 3 from the engine, then read 2, 3, 3.
        eng(1, 1, 16'd2, 32'hAAAA0002); cyc();
        eng(1, 1, 16'd3, 32'hBBBB0003); cyc();
        eng(1, 0, 16'd2, 32'h0); cyc();
        eng(1, 0, 16'd3, 32'h0); cyc();
        eng(1, 0, 16'd3, 32'h0);
        check("b2b_c2", mem_rdata, 32'hAAAA0002);
        cyc();
        eng(0, 0, 16'd0, 32'h0);
        check("b2b_c3", mem_rdata, 32'hBBBB0003);
        cyc();
        check("b2b_c4", mem_rdata, 32'hBBBB0003);
        cyc();

        // Arbitration: host reads addr 7 while the engine reads addr 2.
        hst(1, 1, 16'd7, 32'h77770007); cyc();
        hst(1, 0, 16'd7, 32'h0);
        for (int c = 0; c < 4; c++) begin
            eng(1, 0, 16'd2, 32'h0);
            #1 check($sformatf("arb_gnt0_c%0d", c), host_gnt, 32'h0);
            if (c >= 2) check($sformatf("arb_rvalid0_c%0d", c), host_rvalid, 32'h0);
            cyc();
        end
        eng(0, 0, 16'd0, 32'h0);
        #1 check("arb_gnt1_c4", host_gnt, 32'h1);
        check("arb_rvalid0_c4", host_rvalid, 32'h0);
        cyc();
        hst(0, 0, 16'd0, 32'h0);
        check("arb_rvalid0_c5", host_rvalid, 32'h0);
        check("arb_mem_rdata_c5", mem_rdata, 32'hAAAA0002);
        cyc();
        check("arb_rvalid1_c6", host_rvalid, 32'h1);
        check("arb_host_rdata_c6", host_rdata, 32'h77770007);
        cyc();
        check("arb_rvalid0_c7", host_rvalid, 32'h0);
        check("arb_host_rdata_hold", host_rdata, 32'h77770007);

        // Out of range: write 0x0400 must not alias onto addr 0.
        eng(1, 1, 16'h0000, 32'h0000AAAA); cyc();
        check("oob_err_clear", oob_err, 32'h0);
        eng(1, 1, 16'h0400, 32'h00001234); cyc();
        check("oob_err_set", oob_err, 32'h1);
        eng(1, 0, 16'h0400, 32'h0); cyc();
        eng(1, 0, 16'h0000, 32'h0);
        check("oob_pre_rdata", mem_rdata, 32'hAAAA0002);
        cyc();
        eng(0, 0, 16'd0, 32'h0);
        check("oob_rdata_zero", mem_rdata, 32'h0);
        cyc();
        check("oob_addr0_intact", mem_rdata, 32'h0000AAAA);
        check("oob_err_sticky", oob_err, 32'h1);

        // Reset mid-read: host read granted, reset in the following cycle.
        hst(1, 0, 16'd5, 32'h0); cyc();
        hst(0, 0, 16'd0, 32'h0);
        rst = 1'b1;
        #1 check("rstmid_oob_err", oob_err, 32'h0);
        check("rstmid_mem_rdata", mem_rdata, 32'h0);
        cyc();
        rst = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            check($sformatf("rstmid_rvalid_c%0d", c), host_rvalid, 32'h0);
            cyc();
        end
        hst(1, 0, 16'd5, 32'h0); cyc();
        hst(0, 0, 16'd0, 32'h0); cyc();
        check("rstmid_keep_rvalid", host_rvalid, 32'h1);
        check("rstmid_keep_rdata", host_rdata, 32'hDEAD0001);
        cyc();

        // Host read out of range returns zero with normal valid timing.
        hst(1, 0, 16'h8001, 32'h0); cyc();
        hst(0, 0, 16'd0, 32'h0); cyc();
        check("host_oob_rvalid", host_rvalid, 32'h1);
        check("host_oob_rdata", host_rdata, 32'h0);
        check("host_oob_err", oob_err, 32'h1);
        cyc();

`ifdef MATMUL_MEM_STATS_EN
        rst = 1'b1; cyc(); rst = 1'b0;
        check("stat_rst_rd", rd_count, 32'h0);
        hst(1, 1, 16'd9, 32'h99990009); cyc();
        hst(0, 0, 16'd0, 32'h0);
        eng(1, 1, 16'd10, 32'h1010000A); cyc();
        eng(1, 0, 16'd9, 32'h0); cyc();
        eng(0, 0, 16'd0, 32'h0);
        hst(1, 0, 16'd10, 32'h0); cyc();
        hst(0, 0, 16'd0, 32'h0);
        eng(1, 0, 16'h0400, 32'h0); cyc();
        eng(0, 0, 16'd0, 32'h0);
        check("stat_rd3", rd_count, 32'd3);
        check("stat_wr2", wr_count, 32'd2);
        force dut.rd_count_q = 32'hFFFF_FFFF;
        cyc();
        release dut.rd_count_q;
        eng(1, 0, 16'd9, 32'h0); cyc();
        eng(0, 0, 16'd0, 32'h0); cyc();
        check("stat_rd_sat", rd_count, 32'hFFFF_FFFF);
        check("stat_wr_keep", wr_count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
